// File: rtl/td4_core.sv
// td4_core: 4-bit single-cycle TD4 CPU (A, B, OUT, PC, carry) fetching one byte per cycle from an external ROM.
// Optional build macro TD4_ADD_ONLY_CARRY_EN: only ADD A,Im / ADD B,Im write the carry flag.
module td4_core #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] addr,
  input  logic [7:0] data,
  output logic       cf,
  input  logic [3:0] port_i,
  output logic [3:0] port_o
);

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_A,
    SRC_B,
    SRC_PORT
  } src_e;

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic [3:0] pc_q, pc_d;
  logic       c_q, c_d;

  opcode_e    op;
  logic [3:0] im;
  src_e       srcSel;
  logic [3:0] srcVal;
  logic [4:0] sum;
  logic       wrA, wrB, wrOut, isJmp, isJnc, isAdd, isDefined;

  assign op = opcode_e'(data[7:4]);
  assign im = data[3:0];

  always_comb begin
    srcSel    = SRC_ZERO;
    wrA       = 1'b0;
    wrB       = 1'b0;
    wrOut     = 1'b0;
    isJmp     = 1'b0;
    isJnc     = 1'b0;
    isAdd     = 1'b0;
    isDefined = 1'b1;
    case (op)
      OP_ADD_A:  begin srcSel = SRC_A;    wrA = 1'b1; isAdd = 1'b1; end
      OP_ADD_B:  begin srcSel = SRC_B;    wrB = 1'b1; isAdd = 1'b1; end
      OP_MOV_A:  begin srcSel = SRC_ZERO; wrA = 1'b1; end
      OP_MOV_B:  begin srcSel = SRC_ZERO; wrB = 1'b1; end
      OP_MOV_AB: begin srcSel = SRC_B;    wrA = 1'b1; end
      OP_MOV_BA: begin srcSel = SRC_A;    wrB = 1'b1; end
      OP_IN_A:   begin srcSel = SRC_PORT; wrA = 1'b1; end
      OP_IN_B:   begin srcSel = SRC_PORT; wrB = 1'b1; end
      OP_OUT_B:  begin srcSel = SRC_B;    wrOut = 1'b1; end
      OP_OUT_IM: begin srcSel = SRC_ZERO; wrOut = 1'b1; end
      OP_JMP:    begin srcSel = SRC_ZERO; isJmp = 1'b1; end
      OP_JNC:    begin srcSel = SRC_ZERO; isJnc = 1'b1; end
      default:   isDefined = 1'b0;
    endcase
  end

  always_comb begin
    srcVal = 4'h0;
    case (srcSel)
      SRC_A:    srcVal = a_q;
      SRC_B:    srcVal = b_q;
      SRC_PORT: srcVal = port_i;
      default:  srcVal = 4'h0;
    endcase
    sum = {1'b0, srcVal} + {1'b0, im};
  end

  // JNC tests the carry produced by the previous instruction (c_q), not this one's sum.
  always_comb begin
    a_d   = wrA   ? sum[3:0] : a_q;
    b_d   = wrB   ? sum[3:0] : b_q;
    out_d = wrOut ? sum[3:0] : out_q;
    pc_d  = pc_q + 4'h1;
    if (isJmp || (isJnc && !c_q))
      pc_d = im;
`ifdef TD4_ADD_ONLY_CARRY_EN
    c_d = isAdd ? sum[4] : c_q;
`else
    c_d = isDefined ? sum[4] : 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      out_q <= 4'h0;
      pc_q  <= RESET_PC;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign addr   = pc_q;
  assign cf     = c_q;
  assign port_o = out_q;

endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: table-driven directed test of td4_core; each row supplies the ROM byte for the current PC
// and the expected addr/cf/port_o one step later, followed by a hand-written async-reset sequence.
module tb_td4_core;

  logic       clk;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] data;
  logic       cf;
  logic [3:0] port_i;
  logic [3:0] port_o;

  int vectorCount = 0;
  int missCount   = 0;

  td4_core dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .data   (data),
    .cf     (cf),
    .port_i (port_i),
    .port_o (port_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [7:0] data;
    logic [3:0] portIn;
    logic [3:0] expAddr;
    logic       expCf;
    logic [3:0] expPort;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  // Drive inputs at the falling edge, let the rising edge execute, then sample just after it.
  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic [3:0] p);
    @(negedge clk);
    rst    = r;
    data   = d;
    port_i = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eAddr, input logic eCf,
                             input logic [3:0] ePort);
    vectorCount++;
    if (addr !== eAddr || cf !== eCf || port_o !== ePort) begin
      missCount++;
      $display("[TB] FAIL %s: got addr=%h cf=%b port_o=%h, expected addr=%h cf=%b port_o=%h",
               name, addr, cf, port_o, eAddr, eCf, ePort);
    end
  endtask

  initial begin
    rst    = 1'b1;
    data   = 8'h00;
    port_i = 4'h0;

    //            rst   data   pin   addr  cf    port
    vecs[0]  = '{1'b1, 8'hFF, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 8'h80, 4'h0, 4'h1, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 8'h80, 4'h0, 4'h2, 1'b0, 4'h0};
    vecs[3]  = '{1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 8'h35, 4'h0, 4'h1, 1'b0, 4'h0};
    vecs[5]  = '{1'b0, 8'h40, 4'h0, 4'h2, 1'b0, 4'h0};
    vecs[6]  = '{1'b0, 8'h91, 4'h0, 4'h3, 1'b0, 4'h6};
    vecs[7]  = '{1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 8'h3E, 4'h0, 4'h1, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 8'h01, 4'h0, 4'h2, 1'b0, 4'h0};
    vecs[10] = '{1'b0, 8'hE0, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[11] = '{1'b0, 8'h3F, 4'h0, 4'h1, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 8'h01, 4'h0, 4'h2, 1'b1, 4'h0};
    vecs[13] = '{1'b0, 8'hE0, 4'h0, 4'h3, 1'b0, 4'h0};
    vecs[14] = '{1'b0, 8'hB7, 4'h0, 4'h4, 1'b0, 4'h7};
    vecs[15] = '{1'b0, 8'hF9, 4'h0, 4'h9, 1'b0, 4'h7};
    vecs[16] = '{1'b0, 8'h0F, 4'h0, 4'hA, 1'b0, 4'h7};
    vecs[17] = '{1'b0, 8'hFE, 4'h0, 4'hE, 1'b0, 4'h7};
    vecs[18] = '{1'b0, 8'h01, 4'h0, 4'hF, 1'b1, 4'h7};
    vecs[19] = '{1'b0, 8'h80, 4'h0, 4'h0, 1'b0, 4'h7};
    vecs[20] = '{1'b0, 8'h21, 4'hC, 4'h1, 1'b0, 4'h7};
    vecs[21] = '{1'b0, 8'h40, 4'h0, 4'h2, 1'b0, 4'h7};
    vecs[22] = '{1'b0, 8'h90, 4'h0, 4'h3, 1'b0, 4'hD};
    vecs[23] = '{1'b0, 8'h21, 4'hF, 4'h4, 1'b1, 4'hD};
    vecs[24] = '{1'b0, 8'h75, 4'h0, 4'h5, 1'b0, 4'hD};
    vecs[25] = '{1'b0, 8'h5B, 4'h0, 4'h6, 1'b1, 4'hD};
    vecs[26] = '{1'b0, 8'h13, 4'h0, 4'h7, 1'b0, 4'hD};
    vecs[27] = '{1'b0, 8'h6E, 4'hF, 4'h8, 1'b1, 4'hD};
    vecs[28] = '{1'b0, 8'h94, 4'h0, 4'h9, 1'b1, 4'h1};
    vecs[29] = '{1'b0, 8'hE2, 4'h0, 4'hA, 1'b0, 4'h1};
    vecs[30] = '{1'b0, 8'hE2, 4'h0, 4'h2, 1'b0, 4'h1};
    vecs[31] = '{1'b0, 8'h40, 4'h0, 4'h3, 1'b0, 4'h1};
    vecs[32] = '{1'b0, 8'h9C, 4'h0, 4'h4, 1'b0, 4'hF};
    vecs[33] = '{1'b0, 8'h0D, 4'h0, 4'h5, 1'b1, 4'hF};

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].data, vecs[i].portIn);
      checkOutput($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expCf, vecs[i].expPort);
    end

    // Mid-cycle reset at addr=5 with cf=1 and port_o=F must clear state before any edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 4'h0, 1'b0, 4'h0);

    applyStimulus(1'b1, 8'hF7, 4'h0);
    checkOutput("reset_held", 4'h0, 1'b0, 4'h0);

    applyStimulus(1'b0, 8'h3F, 4'h0);
    checkOutput("after_release_mov", 4'h1, 1'b0, 4'h0);

    // A=F then ADD A,1 sets carry; undefined opcode 1010 must clear it and leave port_o alone.
    applyStimulus(1'b0, 8'h01, 4'h0);
    checkOutput("carry_set", 4'h2, 1'b1, 4'h0);

    applyStimulus(1'b0, 8'hA5, 4'h0);
    checkOutput("undef_1010", 4'h3, 1'b0, 4'h0);

    applyStimulus(1'b0, 8'hD5, 4'h0);
    checkOutput("undef_1101", 4'h4, 1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
